// File: rtl/dmem_pkg.sv
// Shared definitions for the data memory controller: line geometry,
// controller states and the default access latency.
package dmem_pkg;

  localparam int LINE_W          = 256;
  localparam int IDX_W           = 9;
  localparam int CNT_W           = 6;
  localparam int MEM_LATENCY_DEF = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } state_t;

endpackage

// File: rtl/dmem_array.sv
// Line storage: synchronous write port, combinational read port.
// Contents are deliberately not reset so preloaded images survive rst_i.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int MEM_DEPTH = 512
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [IDX_W-1:0]  i_widx,
  input  logic [LINE_W-1:0] i_wdata,
  input  logic [IDX_W-1:0]  i_ridx,
  output logic [LINE_W-1:0] o_rdata
);

  logic [LINE_W-1:0] r_mem [MEM_DEPTH];

  // Line write on the clock edge when the controller commits a write.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_widx] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_ridx];

endmodule

// File: rtl/data_memory_ctrl.sv
// Fixed-latency line memory behind the dcache. A request is captured in
// IDLE, waits MEM_LATENCY cycles in WAIT, then completes with a one-cycle
// ack in ACK. Optional build macro: DMEM_BOUNDS_CHECK_EN adds err_o and
// rejects addresses with any of bits [31:14] set instead of aliasing them.
module data_memory_ctrl
  import dmem_pkg::*;
#(
  parameter int MEM_LATENCY = MEM_LATENCY_DEF,
  parameter int MEM_DEPTH   = 512
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [31:0]       addr_i,
  input  logic [LINE_W-1:0] data_i,
  input  logic              enable_i,
  input  logic              write_i,
  output logic              ack_o,
  output logic [LINE_W-1:0] data_o
`ifdef DMEM_BOUNDS_CHECK_EN
  ,
  output logic              err_o
`endif
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MEM_LATENCY - 1);

  state_t            r_state;
  state_t            w_next;
  logic [CNT_W-1:0]  r_cnt;
  logic [IDX_W-1:0]  r_idx;
  logic [LINE_W-1:0] r_wdata;
  logic              r_write;
  logic [LINE_W-1:0] r_data_o;
  logic [LINE_W-1:0] w_rdata;
  logic              w_cap;
  logic              w_done;
  logic              w_we;
  logic              w_ld;
  logic              w_oob;
  logic              w_unused_addr;

  // Next-state decode; w_done marks the edge that enters ACK.
  always_comb begin
    w_next = r_state;
    w_cap  = 1'b0;
    w_done = 1'b0;
    case (r_state)
      IDLE: begin
        if (enable_i) begin
          w_cap  = 1'b1;
          w_next = WAIT;
        end
      end
      WAIT: begin
        if (r_cnt == LAST_CNT) begin
          w_done = 1'b1;
          w_next = ACK;
        end
      end
      ACK:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // State register and latency counter; reset aborts any pending request.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (w_cap) begin
        r_cnt <= '0;
      end else if (r_state == WAIT) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

`ifdef DMEM_BOUNDS_CHECK_EN
  logic r_oob;

  // Request capture; inputs are ignored outside the capture edge.
  always_ff @(posedge clk_i) begin
    if (w_cap) begin
      r_idx   <= addr_i[13:5];
      r_wdata <= data_i;
      r_write <= write_i;
      r_oob   <= |addr_i[31:14];
    end
  end

  assign w_oob         = r_oob;
  assign err_o         = ack_o & r_oob;
  assign w_unused_addr = ^addr_i[4:0];
`else
  // Request capture; upper address bits alias onto the line index.
  always_ff @(posedge clk_i) begin
    if (w_cap) begin
      r_idx   <= addr_i[13:5];
      r_wdata <= data_i;
      r_write <= write_i;
    end
  end

  assign w_oob         = 1'b0;
  assign w_unused_addr = ^{addr_i[31:14], addr_i[4:0]};
`endif

  assign w_we = w_done & r_write & ~w_oob;
  assign w_ld = w_done & ~r_write;

  // Read data register, loaded only on a read completion and held otherwise.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_data_o <= '0;
    end else if (w_ld) begin
      r_data_o <= w_oob ? '0 : w_rdata;
    end
  end

  assign ack_o  = (r_state == ACK);
  assign data_o = r_data_o;

  dmem_array #(
    .MEM_DEPTH (MEM_DEPTH)
  ) u_array (
    .i_clk   (clk_i),
    .i_we    (w_we),
    .i_widx  (r_idx),
    .i_wdata (r_wdata),
    .i_ridx  (r_idx),
    .o_rdata (w_rdata)
  );

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Scoreboard bench for data_memory_ctrl: one instance at the default latency
// and one at latency 1. Expected responses are queued at capture time and
// checked by per-instance monitors on the falling clock edge.
module tb_data_memory_ctrl;
  import dmem_pkg::*;

  localparam int LAT0 = 10;
  localparam int LAT1 = 1;

  typedef struct {
    logic              rd;
    logic [LINE_W-1:0] data;
    int                cap;
    logic              err;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [31:0]       addr0 = '0, addr1 = '0;
  logic [LINE_W-1:0] din0 = '0, din1 = '0;
  logic              en0 = 1'b0, en1 = 1'b0;
  logic              wr0 = 1'b0, wr1 = 1'b0;
  logic              ack0, ack1;
  logic [LINE_W-1:0] dout0, dout1;
  logic              err0, err1;

  exp_t              q0[$];
  exp_t              q1[$];
  exp_t              m0, m1;
  logic [LINE_W-1:0] last_rd [2];
  int                cyc = 0;
  int                n_cmp = 0;
  int                n_fail = 0;
  int                cap;

  logic [LINE_W-1:0] P_A5, P_3C, P_11, P_EE, P_77, P_5A, P_C3, P_GB;

`ifdef DMEM_BOUNDS_CHECK_EN
  data_memory_ctrl #(.MEM_LATENCY(LAT0), .MEM_DEPTH(512)) dut0 (
    .clk_i(clk), .rst_i(rst), .addr_i(addr0), .data_i(din0), .enable_i(en0),
    .write_i(wr0), .ack_o(ack0), .data_o(dout0), .err_o(err0));
  data_memory_ctrl #(.MEM_LATENCY(LAT1), .MEM_DEPTH(512)) dut1 (
    .clk_i(clk), .rst_i(rst), .addr_i(addr1), .data_i(din1), .enable_i(en1),
    .write_i(wr1), .ack_o(ack1), .data_o(dout1), .err_o(err1));
`else
  data_memory_ctrl #(.MEM_LATENCY(LAT0), .MEM_DEPTH(512)) dut0 (
    .clk_i(clk), .rst_i(rst), .addr_i(addr0), .data_i(din0), .enable_i(en0),
    .write_i(wr0), .ack_o(ack0), .data_o(dout0));
  data_memory_ctrl #(.MEM_LATENCY(LAT1), .MEM_DEPTH(512)) dut1 (
    .clk_i(clk), .rst_i(rst), .addr_i(addr1), .data_i(din1), .enable_i(en1),
    .write_i(wr1), .ack_o(ack1), .data_o(dout1));
  assign err0 = 1'b0;
  assign err1 = 1'b0;
`endif

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [LINE_W-1:0] act,
                       input logic [LINE_W-1:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Compare one completion against its queued expectation. The ack is
  // registered high from edge cap+LAT and seen by the dcache on edge
  // cap+LAT+1, which is the edge number reported here.
  task automatic score(input string tag, input exp_t e, input int lat,
                       input logic [LINE_W-1:0] dout, input logic err);
    check({tag, "_ack_edge"}, LINE_W'(cyc - e.cap + 1), LINE_W'(lat + 1));
    check(e.rd ? {tag, "_rd_data"} : {tag, "_wr_data_hold"}, dout, e.data);
`ifdef DMEM_BOUNDS_CHECK_EN
    check({tag, "_err"}, LINE_W'(err), LINE_W'(e.err));
`else
    if (err !== 1'b0) check({tag, "_err_stub"}, LINE_W'(err), '0);
`endif
  endtask

  // Monitors: every ack must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (ack0 === 1'b1) begin
      if (q0.size() == 0) begin
        n_cmp++; n_fail++;
        $display("FAIL dut0_unexpected_ack: got ack=1, expected no ack at cycle %0d", cyc);
      end else begin
        m0 = q0.pop_front();
        score("dut0", m0, LAT0, dout0, err0);
      end
    end
    if (ack1 === 1'b1) begin
      if (q1.size() == 0) begin
        n_cmp++; n_fail++;
        $display("FAIL dut1_unexpected_ack: got ack=1, expected no ack at cycle %0d", cyc);
      end else begin
        m1 = q1.pop_front();
        score("dut1", m1, LAT1, dout1, err1);
      end
    end
  end

  // Drive one request and return its capture cycle; optionally queue the
  // expected completion (write completions expect data_o unchanged).
  task automatic issue(input int s, input logic wr, input logic [31:0] a,
                       input logic [LINE_W-1:0] d, input logic [LINE_W-1:0] exp_rd,
                       input logic exp_err, input bit push, output int c);
    exp_t e;
    @(posedge clk); #1;
    if (s == 0) begin en0 = 1; wr0 = wr; addr0 = a; din0 = d; end
    else        begin en1 = 1; wr1 = wr; addr1 = a; din1 = d; end
    @(posedge clk); #1;
    c = cyc;
    if (s == 0) en0 = 0; else en1 = 0;
    if (push) begin
      e.rd  = !wr;
      e.data = wr ? last_rd[s] : exp_rd;
      e.cap = c;
      e.err = exp_err;
      if (!wr) last_rd[s] = exp_rd;
      if (s == 0) q0.push_back(e); else q1.push_back(e);
    end
  endtask

  task automatic wait_ack(input int s);
    bit got = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (((s == 0) ? ack0 : ack1) === 1'b1) begin got = 1; break; end
    end
    if (!got) begin
      n_cmp++; n_fail++;
      $display("FAIL ack_timeout dut%0d: got no ack in 100 cycles, expected ack", s);
    end
  endtask

  task automatic xfer(input int s, input logic wr, input logic [31:0] a,
                      input logic [LINE_W-1:0] d, input logic [LINE_W-1:0] exp_rd,
                      input logic exp_err);
    int c;
    issue(s, wr, a, d, exp_rd, exp_err, 1'b1, c);
    wait_ack(s);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    P_A5 = {32{8'hA5}}; P_3C = {32{8'h3C}}; P_11 = {32{8'h11}};
    P_EE = {32{8'hEE}}; P_77 = {32{8'h77}}; P_5A = {32{8'h5A}};
    P_C3 = {32{8'hC3}}; P_GB = {32{8'hF0}};
    last_rd[0] = '0;
    last_rd[1] = '0;

    // Reset state
    @(negedge clk);
    check("rst_ack0", LINE_W'(ack0), '0);
    check("rst_dout0", dout0, '0);
    check("rst_ack1", LINE_W'(ack1), '0);
    check("rst_dout1", dout1, '0);
    @(posedge clk); #1 rst = 0;

    // Write then read back line 2
    xfer(0, 1'b1, 32'h0000_0040, P_A5, '0, 1'b0);
    xfer(0, 1'b0, 32'h0000_0040, '0, P_A5, 1'b0);

    // Inputs changed during WAIT are ignored (read 0x40, switch to 0x80 write)
    xfer(0, 1'b1, 32'h0000_0080, P_3C, '0, 1'b0);
    issue(0, 1'b0, 32'h0000_0040, '0, P_A5, 1'b0, 1'b1, cap);
    addr0 = 32'h0000_0080; wr0 = 1'b1; din0 = P_GB;
    wait_ack(0);
    xfer(0, 1'b0, 32'h0000_0080, '0, P_3C, 1'b0);

    // Held request: captures at 0, 12 and 24; acks seen on edges 11, 23, 35
    @(posedge clk); #1;
    en0 = 1; wr0 = 0; addr0 = 32'h0000_0040;
    @(posedge clk); #1;
    cap = cyc;
    for (int i = 0; i < 3; i++) begin
      exp_t e;
      e.rd = 1'b1; e.data = P_A5; e.cap = cap + i * (LAT0 + 2); e.err = 1'b0;
      q0.push_back(e);
    end
    last_rd[0] = P_A5;
    repeat (29) @(posedge clk);
    #1 en0 = 0;
    repeat (20) @(posedge clk);
    check("held_all_acks_seen", LINE_W'(q0.size()), '0);

    // Reset 5 cycles into a write: no ack, no write, data_o cleared
    xfer(0, 1'b1, 32'h0000_0100, P_11, '0, 1'b0);
    issue(0, 1'b1, 32'h0000_0100, P_EE, '0, 1'b0, 1'b0, cap);
    repeat (4) @(posedge clk);
    #1 rst = 1;
    @(negedge clk);
    check("midrst_ack0", LINE_W'(ack0), '0);
    check("midrst_dout0", dout0, '0);
    @(posedge clk); #1 rst = 0;
    last_rd[0] = '0;
    last_rd[1] = '0;
    repeat (15) @(posedge clk);
    xfer(0, 1'b0, 32'h0000_0100, '0, P_11, 1'b0);

    // Upper address bits: rejected with err_o, or aliased onto line 0
    xfer(0, 1'b1, 32'h0000_0000, P_77, '0, 1'b0);
`ifdef DMEM_BOUNDS_CHECK_EN
    xfer(0, 1'b1, 32'h0000_4000, P_5A, '0, 1'b1);
    xfer(0, 1'b0, 32'h0000_0000, '0, P_77, 1'b0);
    xfer(0, 1'b0, 32'h0000_4000, '0, '0, 1'b1);
`else
    xfer(0, 1'b1, 32'h0000_4000, P_5A, '0, 1'b0);
    xfer(0, 1'b0, 32'h0000_0000, '0, P_5A, 1'b0);
    xfer(0, 1'b0, 32'h0000_4000, '0, P_5A, 1'b0);
`endif

    // Latency-1 instance: ack seen two edges after capture
    xfer(1, 1'b1, 32'h0000_0020, P_C3, '0, 1'b0);
    xfer(1, 1'b0, 32'h0000_0020, '0, P_C3, 1'b0);

    repeat (5) @(posedge clk);
    check("q0_drained", LINE_W'(q0.size()), '0);
    check("q1_drained", LINE_W'(q1.size()), '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
